// File: rtl/rtype_control_unit.sv
// rtype_control_unit: multi-cycle RV32I R-type decode/execute/writeback sequencer
module rtype_control_unit #(
  parameter int CNT_W       = 16,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       mem_read_addr_1,
  output logic [4:0]       mem_read_addr_2,
  output logic [4:0]       mem_write_addr,
  output logic [3:0]       alu_ctrl,
  output logic             r_or_w,
  input  logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             last_zero,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, WRITEBACK, TRAP} state_t;
  state_t           r_state;
  logic [31:0]      r_instr;
  logic             r_ready, r_busy, r_done, r_illegal, r_wr, r_last_zero;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [3:0]       r_alu;
  logic [CNT_W-1:0] r_count;
  logic             w_legal;
  logic [3:0]       w_alu;
  // Decode the latched instruction into legality and ALU operation
  always_comb begin
    w_legal = r_instr[6:0] == 7'b0110011;
    w_alu   = 4'd0;
    case ({r_instr[31:25], r_instr[14:12]})
      {7'h00, 3'd0}: w_alu = 4'd0;
      {7'h20, 3'd0}: w_alu = 4'd1;
      {7'h00, 3'd1}: w_alu = 4'd2;
      {7'h00, 3'd2}: w_alu = 4'd3;
      {7'h00, 3'd3}: w_alu = 4'd4;
      {7'h00, 3'd4}: w_alu = 4'd5;
      {7'h00, 3'd5}: w_alu = 4'd6;
      {7'h20, 3'd5}: w_alu = 4'd7;
      {7'h00, 3'd6}: w_alu = 4'd8;
      {7'h00, 3'd7}: w_alu = 4'd9;
      default:       w_legal = 1'b0;
    endcase
  end
  // Sequencer with registered outputs; pulses default low each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_wr        <= 1'b0;
      r_last_zero <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_alu       <= '0;
      r_count     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_wr      <= 1'b0;
      case (r_state)
        IDLE: if (instr_valid) begin
          r_instr <= instr;
          r_state <= DECODE;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
        DECODE: if (w_legal) begin
          r_rs1   <= r_instr[19:15];
          r_rs2   <= r_instr[24:20];
          r_rd    <= r_instr[11:7];
          r_alu   <= w_alu;
          r_state <= EXECUTE;
        end else begin
          r_illegal <= 1'b1;
          r_state   <= TRAP;
        end
        EXECUTE: begin
          r_wr    <= !(SUPPRESS_X0 && r_rd == 5'd0);
          r_done  <= 1'b1;
          r_state <= WRITEBACK;
        end
        WRITEBACK: begin
          r_last_zero <= zero_flag;
          r_count     <= r_count + 1'b1;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign instr_ready     = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign illegal         = r_illegal;
  assign r_or_w          = r_wr;
  assign last_zero       = r_last_zero;
  assign mem_read_addr_1 = r_rs1;
  assign mem_read_addr_2 = r_rs2;
  assign mem_write_addr  = r_rd;
  assign alu_ctrl        = r_alu;
  assign retired_count   = r_count;
endmodule

// File: tb/tb_rtype_control_unit.sv
// tb_rtype_control_unit: randomized check of the R-type control unit against a table-driven model
module tb_rtype_control_unit;
  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, zero_flag = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready, r_or_w, busy, done, illegal, last_zero;
  logic [4:0]  mem_read_addr_1, mem_read_addr_2, mem_write_addr;
  logic [3:0]  alu_ctrl, retired_count;
  int          n_chk = 0, n_pass = 0;
  logic [9:0]  ops [10] = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                            10'h004, 10'h005, 10'h105, 10'h006, 10'h007};
  logic [4:0]  e_rs1 = '0, e_rs2 = '0, e_rd = '0;
  logic [3:0]  e_alu = '0, e_cnt = '0;
  logic        e_lz = 1'b0;

  rtype_control_unit #(.CNT_W(4), .SUPPRESS_X0(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .mem_read_addr_1(mem_read_addr_1), .mem_read_addr_2(mem_read_addr_2),
    .mem_write_addr(mem_write_addr), .alu_ctrl(alu_ctrl), .r_or_w(r_or_w),
    .zero_flag(zero_flag), .busy(busy), .done(done), .illegal(illegal),
    .last_zero(last_zero), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {legal, alu_ctrl}: ALU code is the position of the (funct7,funct3) pair in the table
  function automatic logic [4:0] ref_dec(input logic [31:0] w);
    for (int i = 0; i < 10; i++)
      if (w[6:0] == 7'h33 && {w[31:25], w[14:12]} == ops[i]) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".ready"}, instr_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".illegal"}, illegal, 0);
    chk({tag, ".r_or_w"}, r_or_w, 0);
    chk({tag, ".rs1"}, mem_read_addr_1, e_rs1);
    chk({tag, ".rs2"}, mem_read_addr_2, e_rs2);
    chk({tag, ".rd"}, mem_write_addr, e_rd);
    chk({tag, ".alu"}, alu_ctrl, e_alu);
    chk({tag, ".count"}, retired_count, e_cnt);
    chk({tag, ".last_zero"}, last_zero, e_lz);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge it is idle again
  task automatic run(input logic [31:0] w, input logic zf);
    logic [4:0] d;
    d = ref_dec(w);
    chk("accept.ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = w;
    zero_flag   = zf;
    @(negedge clk);
    chk("dec.busy", busy, 1);
    chk("dec.ready", instr_ready, 0);
    chk("dec.r_or_w", r_or_w, 0);
    chk("dec.done", done, 0);
    chk("dec.illegal", illegal, 0);
    instr_valid = 1'($urandom);
    instr       = $urandom;
    @(negedge clk);
    if (d[4]) begin
      e_rs1 = w[19:15];
      e_rs2 = w[24:20];
      e_rd  = w[11:7];
      e_alu = d[3:0];
    end
    chk("ex.rs1", mem_read_addr_1, e_rs1);
    chk("ex.rs2", mem_read_addr_2, e_rs2);
    chk("ex.rd", mem_write_addr, e_rd);
    chk("ex.alu", alu_ctrl, e_alu);
    chk("ex.illegal", illegal, !d[4]);
    chk("ex.r_or_w", r_or_w, 0);
    chk("ex.done", done, 0);
    chk("ex.ready", instr_ready, 0);
    instr_valid = 1'($urandom);
    instr       = $urandom;
    if (d[4]) begin
      @(negedge clk);
      chk("wb.r_or_w", r_or_w, e_rd != 5'd0);
      chk("wb.done", done, 1);
      chk("wb.busy", busy, 1);
      chk("wb.illegal", illegal, 0);
      chk("wb.count", retired_count, e_cnt);
      chk("wb.alu", alu_ctrl, e_alu);
      instr_valid = 1'($urandom);
    end
    @(negedge clk);
    if (d[4]) begin
      e_cnt++;
      e_lz = zf;
    end
    instr_valid = 1'b0;
    check_idle("idle");
  endtask

  initial begin
    logic [31:0] w;
    int k;
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset       = 1'b0;
    instr_valid = 1'b0;
    run(32'h002081B3, 1'b0);
    run(32'h407302B3, 1'b1);
    run(32'h00100093, 1'b0);
    run(32'h00208033, 1'b1);
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b1;
    @(negedge clk);
    {e_rs1, e_rs2, e_rd, e_alu, e_cnt, e_lz} = '0;
    check_idle("midreset");
    @(negedge clk);
    check_idle("reset_valid");
    reset       = 1'b0;
    instr_valid = 1'b0;
    run(32'h002081B3, 1'b1);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      w = {ops[k][9:3], 5'($urandom), 5'($urandom), ops[k][2:0], 5'($urandom), 7'h33};
      case ($urandom_range(0, 4))
        0: w = $urandom;
        1: w = w ^ (32'd1 << (25 + $urandom_range(0, 6)));
        2: w[11:7] = 5'd0;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run(w, 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
